serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 124 ++++++++++++
 tb/tb_serial_subtractor.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell walks the operands LSB first,
// producing (a - b - bin) mod 2^WIDTH and the final borrow after WIDTH shift cycles.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] d_sr_q, d_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_ff_q, borrow_ff_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic cell_x, cell_y, cell_z, cell_d, cell_bo;

  always_comb begin
    cell_x  = a_sr_q[0];
    cell_y  = b_sr_q[0];
    cell_z  = borrow_ff_q;
    cell_d  = cell_x ^ cell_y ^ cell_z;
    cell_bo = (~cell_x & cell_y) | (~cell_x & cell_z) | (cell_y & cell_z);
  end

  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    d_sr_d      = d_sr_q;
    diff_d      = diff_q;
    cnt_d       = cnt_q;
    borrow_ff_d = borrow_ff_q;
    borrow_d    = borrow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d      = a;
          b_sr_d      = b;
          borrow_ff_d = bin;
          cnt_d       = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        d_sr_d      = {cell_d, d_sr_q[WIDTH-1:1]};
        a_sr_d      = a_sr_q >> 1;
        b_sr_d      = b_sr_q >> 1;
        borrow_ff_d = cell_bo;
        cnt_d       = cnt_q + CW'(1);
        // The last bit lands in the result registers on the same edge it is computed.
        if (cnt_q == LAST_BIT) begin
          diff_d   = {cell_d, d_sr_q[WIDTH-1:1]};
          borrow_d = cell_bo;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      d_sr_q      <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      borrow_ff_q <= 1'b0;
      borrow_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      d_sr_q      <= d_sr_d;
      diff_q      <= diff_d;
      cnt_q       <= cnt_d;
      borrow_ff_q <= borrow_ff_d;
      borrow_q    <= borrow_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: an 8-bit instance runs directed and random
// operations, a 4-bit instance runs every (a, b, bin) combination in shuffled order.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, bin8, busy8, done8, borrow8;
  logic [7:0] a8, b8, diff8;
  logic       start4, bin4, busy4, done4, borrow4;
  logic [3:0] a4, b4, diff4;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
  );

  typedef struct {
    logic [31:0] diff;
    logic        borrow;
    int          cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];

  int   cyc = 0;
  bit   rst_seen = 1'b0;
  int   rem8 = 0, rem4 = 0;
  bit   exp_busy8 = 1'b0, exp_done8 = 1'b0, exp_busy4 = 1'b0, exp_done4 = 1'b0;
  bit   final_req = 1'b0, final_done = 1'b0;
  int   checks = 0, failures = 0;

  logic [7:0] held_d8 = '0;
  logic       held_b8 = 1'b0;
  logic [3:0] held_d4 = '0;
  logic       held_b4 = 1'b0;

  // Plain-arithmetic reference: wrapped difference and unsigned borrow.
  function automatic exp_t ref_op(int w, int av, int bv, int binv, int c);
    exp_t e;
    int r;
    r        = av - bv - binv;
    e.diff   = 32'(r) & ((32'd1 << w) - 32'd1);
    e.borrow = (av < bv + binv);
    e.cyc    = c;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: an operation occupies the unit for WIDTH+2 edges after acceptance;
  // the first WIDTH of those cycles are busy and the next one is the done cycle.
  always @(posedge clk) begin
    cyc++;
    rst_seen = rst;
    if (rst) begin
      rem8 = 0;
      rem4 = 0;
    end else begin
      if (rem8 == 0) begin
        if (start8) begin
          q8.push_back(ref_op(8, int'(a8), int'(b8), int'(bin8), cyc));
          rem8 = 9;
        end
      end else begin
        rem8--;
      end
      if (rem4 == 0) begin
        if (start4) begin
          q4.push_back(ref_op(4, int'(a4), int'(b4), int'(bin4), cyc));
          rem4 = 5;
        end
      end else begin
        rem4--;
      end
    end
    exp_busy8 = (rem8 >= 2);
    exp_done8 = (rem8 == 1);
    exp_busy4 = (rem4 >= 2);
    exp_done4 = (rem4 == 1);
  end

  // Monitor: pops the scoreboard on each DUT done pulse, and every cycle checks the
  // handshake outputs and that the result registers hold their last completed value.
  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      q8.delete();
      q4.delete();
      held_d8 = '0;
      held_b8 = 1'b0;
      held_d4 = '0;
      held_b4 = 1'b0;
    end
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL spurious_done8: got done with empty scoreboard, required no done (cycle %0d)", cyc);
      end else begin
        e       = q8.pop_front();
        held_d8 = e.diff[7:0];
        held_b8 = e.borrow;
        checkOutput("latency8", 32'(cyc - e.cyc + 1), 32'd9);
      end
    end
    if (done4 === 1'b1) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL spurious_done4: got done with empty scoreboard, required no done (cycle %0d)", cyc);
      end else begin
        e       = q4.pop_front();
        held_d4 = e.diff[3:0];
        held_b4 = e.borrow;
        checkOutput("latency4", 32'(cyc - e.cyc + 1), 32'd5);
      end
    end
    checkOutput("busy8", 32'(busy8), 32'(exp_busy8));
    checkOutput("done8", 32'(done8), 32'(exp_done8));
    checkOutput("diff8", 32'(diff8), 32'(held_d8));
    checkOutput("borrow8", 32'(borrow8), 32'(held_b8));
    checkOutput("busy4", 32'(busy4), 32'(exp_busy4));
    checkOutput("done4", 32'(done4), 32'(exp_done4));
    checkOutput("diff4", 32'(diff4), 32'(held_d4));
    checkOutput("borrow4", 32'(borrow4), 32'(held_b4));
    if (final_req && !final_done) begin
      final_done = 1'b1;
      checkOutput("drained8", 32'(q8.size()), 32'd0);
      checkOutput("drained4", 32'(q4.size()), 32'd0);
    end
  end

  // One-cycle start pulse, then scramble operands and wait out the full WIDTH+2 period.
  task automatic applyStimulus(input bit wide8, input logic [7:0] av, input logic [7:0] bv,
                               input logic binv);
    if (wide8) begin
      start8 = 1'b1; a8 = av; b8 = bv; bin8 = binv;
    end else begin
      start4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0]; bin4 = binv;
    end
    @(negedge clk);
    start8 = 1'b0;
    start4 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
    repeat (wide8 ? 9 : 5) @(negedge clk);
  endtask

  int order[512];

  initial begin
    rst = 1'b1;
    start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    start4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start8 = 1'b0;
    start4 = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] directed 8-bit operations");
    applyStimulus(1'b1, 8'h5A, 8'h23, 1'b0);
    repeat (4) @(negedge clk);
    applyStimulus(1'b1, 8'h10, 8'h20, 1'b1);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1);
    applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b0);

    $display("[TB] start held high across two operations");
    start8 = 1'b1; a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0;
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h01;
    repeat (12) @(negedge clk);
    start8 = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] reset during the fourth busy cycle");
    start8 = 1'b1; a8 = 8'h3C; b8 = 8'h11; bin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 8'h80, 8'h01, 1'b0);

    $display("[TB] random 8-bit operations");
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("[TB] exhaustive 4-bit operations in shuffled order");
    for (int i = 0; i < 512; i++) order[i] = i;
    for (int i = 511; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(order[i]);
      applyStimulus(1'b0, {4'h0, v[8:5]}, {4'h0, v[4:1]}, v[0]);
    end

    repeat (3) @(negedge clk);
    final_req = 1'b1;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
